// File: rtl/logic_result_stage.sv
// Two-entry registered output stage for the logic unit: buffers result/op with
// precomputed Z/N/INV flags and delivers them over valid/ready, counting pops.
module logic_result_stage #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     res_in,
    input  logic [2:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     res_out,
    output logic [2:0]       op_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_inv,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt,
    output logic [1:0]       occupancy
);

    typedef struct packed {
        logic [N-1:0] res;
        logic [2:0]   op;
        logic         z;
        logic         n;
        logic         inv;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    entry_t           head_q, head_d, tail_q, tail_d, new_entry;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop, new_inv;
    logic [N-1:0]     new_res;

    // Unused/no-op op codes carry no meaningful result, so the data is zeroed.
    always_comb begin
        new_inv       = op_in[2] & op_in[1];
        new_res       = new_inv ? '0 : res_in;
        new_entry.res = new_res;
        new_entry.op  = op_in;
        new_entry.z   = ~|new_res;
        new_entry.n   = new_res[N-1];
        new_entry.inv = new_inv;
    end

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = new_entry;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    tail_d = new_entry;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    head_d = '0;
                    occ_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    tail_d = '0;
                    occ_d  = 2'd1;
                end
            end
            default: begin
                head_d = '0;
                tail_d = '0;
                occ_d  = 2'd0;
            end
        endcase
    end

    // Clear takes priority over a simultaneous pop.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (pop && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

    assign res_out   = head_q.res;
    assign op_out    = head_q.op;
    assign flag_z    = head_q.z;
    assign flag_n    = head_q.n;
    assign flag_inv  = head_q.inv;
    assign done_cnt  = cnt_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Scoreboard bench for logic_result_stage: two instances (CNT_W=8 and CNT_W=2)
// share stimulus so the counter saturation corner is exercised alongside the FIFO checks.
module tb_logic_result_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] res_in;
    logic [2:0] op_in;
    logic       out_ready;
    logic       cnt_clr;

    logic       in_ready_a, out_valid_a, flag_z_a, flag_n_a, flag_inv_a;
    logic [3:0] res_out_a;
    logic [2:0] op_out_a;
    logic [7:0] done_cnt_a;
    logic [1:0] occupancy_a;

    logic       in_ready_b, out_valid_b, flag_z_b, flag_n_b, flag_inv_b;
    logic [3:0] res_out_b;
    logic [2:0] op_out_b;
    logic [1:0] done_cnt_b;
    logic [1:0] occupancy_b;

    typedef struct packed {
        logic [3:0] res;
        logic [2:0] op;
        logic       z;
        logic       n;
        logic       inv;
    } exp_t;

    exp_t expQ[$];
    int   cnt8;
    int   cnt2;
    int   checks;
    int   passes;

    logic_result_stage #(.N(4), .CNT_W(8)) dutA (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .res_in(res_in), .op_in(op_in), .out_valid(out_valid_a), .out_ready(out_ready),
        .res_out(res_out_a), .op_out(op_out_a), .flag_z(flag_z_a), .flag_n(flag_n_a),
        .flag_inv(flag_inv_a), .cnt_clr(cnt_clr), .done_cnt(done_cnt_a), .occupancy(occupancy_a)
    );

    logic_result_stage #(.N(4), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .res_in(res_in), .op_in(op_in), .out_valid(out_valid_b), .out_ready(out_ready),
        .res_out(res_out_b), .op_out(op_out_b), .flag_z(flag_z_b), .flag_n(flag_n_b),
        .flag_inv(flag_inv_b), .cnt_clr(cnt_clr), .done_cnt(done_cnt_b), .occupancy(occupancy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
    endtask

    function automatic exp_t makeExpected(input logic [3:0] r, input logic [2:0] o);
        exp_t e;
        e.op  = o;
        e.inv = (o == 3'b110) || (o == 3'b111);
        e.res = e.inv ? 4'b0000 : r;
        e.z   = (e.res == 4'b0000);
        e.n   = e.res[3];
        return e;
    endfunction

    task automatic checkHead(input string tag);
        checkOutput({tag, " occA"}, 32'(occupancy_a), 32'(expQ.size()));
        checkOutput({tag, " occB"}, 32'(occupancy_b), 32'(expQ.size()));
        checkOutput({tag, " validA"}, 32'(out_valid_a), 32'(expQ.size() != 0));
        checkOutput({tag, " readyA"}, 32'(in_ready_a), 32'(expQ.size() < 2));
        checkOutput({tag, " cntA"}, 32'(done_cnt_a), 32'(cnt8));
        checkOutput({tag, " cntB"}, 32'(done_cnt_b), 32'(cnt2));
        if (expQ.size() != 0) begin
            checkOutput({tag, " resA"}, 32'(res_out_a), 32'(expQ[0].res));
            checkOutput({tag, " opA"}, 32'(op_out_a), 32'(expQ[0].op));
            checkOutput({tag, " flagsA"}, {29'd0, flag_z_a, flag_n_a, flag_inv_a},
                        {29'd0, expQ[0].z, expQ[0].n, expQ[0].inv});
            checkOutput({tag, " resB"}, 32'(res_out_b), 32'(expQ[0].res));
        end
    endtask

    // One cycle: drive at negedge, check registered outputs, then advance the model at posedge.
    task automatic applyStimulus(input string tag, input logic iv, input logic [3:0] r,
                                 input logic [2:0] o, input logic ordy, input logic clr);
        logic pushM, popM;
        @(negedge clk);
        in_valid  = iv;
        res_in    = r;
        op_in     = o;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        checkHead(tag);
        pushM = iv && (expQ.size() < 2);
        popM  = ordy && (expQ.size() != 0);
        @(posedge clk);
        if (popM) void'(expQ.pop_front());
        if (pushM) expQ.push_back(makeExpected(r, o));
        if (clr) begin
            cnt8 = 0;
            cnt2 = 0;
        end else if (popM) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3) cnt2++;
        end
    endtask

    task automatic resetNow(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        expQ.delete();
        cnt8 = 0;
        cnt2 = 0;
        checkOutput({tag, " asyncOccA"}, 32'(occupancy_a), 32'd0);
        checkOutput({tag, " asyncValidA"}, 32'(out_valid_a), 32'd0);
        checkOutput({tag, " asyncValidB"}, 32'(out_valid_b), 32'd0);
        checkOutput({tag, " asyncResA"}, 32'(res_out_a), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        cnt8      = 0;
        cnt2      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        res_in    = 4'd0;
        op_in     = 3'd0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;

        resetNow("reset");
        applyStimulus("idle", 0, 4'h0, 3'b000, 0, 0);
        checkOutput("idle flagsA", {29'd0, flag_z_a, flag_n_a, flag_inv_a}, 32'd0);
        checkOutput("idle opA", 32'(op_out_a), 32'd0);

        applyStimulus("single push", 1, 4'b1000, 3'b011, 1, 0);
        applyStimulus("single pop", 0, 4'h0, 3'b000, 1, 0);
        applyStimulus("single done", 0, 4'h0, 3'b000, 0, 0);

        applyStimulus("bp push1", 1, 4'b0101, 3'b000, 0, 0);
        applyStimulus("bp push2", 1, 4'b0000, 3'b010, 0, 0);
        applyStimulus("bp push3", 1, 4'b1111, 3'b001, 0, 0);
        applyStimulus("bp hold", 0, 4'h0, 3'b000, 0, 0);
        applyStimulus("bp pop1", 0, 4'h0, 3'b000, 1, 0);
        applyStimulus("bp pop2", 0, 4'h0, 3'b000, 1, 0);
        applyStimulus("bp done", 0, 4'h0, 3'b000, 0, 0);

        applyStimulus("cc push", 1, 4'b1111, 3'b001, 0, 0);
        applyStimulus("cc both", 1, 4'b0011, 3'b100, 1, 0);
        applyStimulus("cc pop", 0, 4'h0, 3'b000, 1, 0);

        applyStimulus("inv push7", 1, 4'b1010, 3'b111, 0, 0);
        applyStimulus("inv push6", 1, 4'b0110, 3'b110, 1, 0);
        applyStimulus("inv pop", 0, 4'h0, 3'b000, 1, 0);
        applyStimulus("inv done", 0, 4'h0, 3'b000, 0, 0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0));
        end

        applyStimulus("sat clear", 0, 4'h0, 3'b000, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("sat push", 1, 4'($urandom_range(0, 15)), 3'b001, 0, 0);
            applyStimulus("sat pop", 0, 4'h0, 3'b000, 1, 0);
        end
        applyStimulus("sat push", 1, 4'b0111, 3'b000, 0, 0);
        checkOutput("saturated cntB", 32'(done_cnt_b), 32'd3);
        applyStimulus("clr with pop", 0, 4'h0, 3'b000, 1, 1);
        applyStimulus("clr done", 0, 4'h0, 3'b000, 0, 0);
        checkOutput("clr wins cntA", 32'(done_cnt_a), 32'd0);

        applyStimulus("full push1", 1, 4'b1001, 3'b000, 0, 0);
        applyStimulus("full push2", 1, 4'b0100, 3'b101, 0, 0);
        applyStimulus("full hold", 0, 4'h0, 3'b000, 0, 0);
        resetNow("mid reset");
        applyStimulus("post reset", 0, 4'h0, 3'b000, 1, 0);
        applyStimulus("post push", 1, 4'b1100, 3'b010, 0, 0);
        applyStimulus("post pop", 0, 4'h0, 3'b000, 1, 0);
        applyStimulus("post done", 0, 4'h0, 3'b000, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
